// File: rtl/fire3_squeeze_pkg.sv
// Shared constants and types for the fire3 squeeze post-accumulation stage.
package fire3_squeeze_pkg;

  localparam int NUM_CH     = 16;    // channels per pixel, equals bias bank depth
  localparam int ACC_W      = 32;    // signed accumulator / bias width
  localparam int OUT_W      = 16;    // signed output width
  localparam int FRAC_SHIFT = 8;     // right shift applied after the bias add
  localparam int NUM_PIX    = 3025;  // pixels per frame (55x55)

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SUM_W = ACC_W + 1;  // bias add widened by one bit so it never overflows

  typedef logic [CH_W-1:0]          ch_idx_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef acc_t [NUM_CH-1:0]        bias_bank_t;
  typedef logic [OUT_W-1:0]         out_t;

endpackage

// File: rtl/fire_requant_relu.sv
// Combinational ReLU + requantizer: clamps negative sums to zero, shifts right
// by FRAC_SHIFT and saturates to the largest positive OUT_W-bit value.
// Shared by the fire stages; o_sat marks a clamped-high result.
module fire_requant_relu #(
  parameter int SUM_W      = 33,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [SUM_W-1:0] i_sum,
  output logic        [OUT_W-1:0] o_value,
  output logic                    o_sat
);

  localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};

  logic signed [SUM_W-1:0] w_shift;

  assign w_shift = i_sum >>> FRAC_SHIFT;

  // ReLU first, then saturate anything that does not fit the positive output range.
  always_comb begin
    // NOTE: outputs get defaults first so every path assigns them and no latch is inferred.
    o_value = '0;
    o_sat   = 1'b0;
    if (i_sum[SUM_W-1]) begin
      o_value = '0;
    end else if (|w_shift[SUM_W-1:OUT_W-1]) begin
      o_value = MAX_VAL;
      o_sat   = 1'b1;
    end else begin
      o_value = w_shift[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fire3_squeeze_bias_relu.sv
// fire3 squeeze post-accumulation stage: bias add, ReLU, requantize to 16 bits,
// valid/ready output with channel tag, last-channel flag and end-of-frame pulse.
// Two register stages (S1: biased sum, S2: requantized result), 1 beat/cycle.
// Optional macro FIRE3_SQUEEZE_SAT_STATS_EN enables the saturated-beat counter
// on sat_count; without it sat_count is tied to zero.
module fire3_squeeze_bias_relu #(
  parameter int NUM_PIX = fire3_squeeze_pkg::NUM_PIX
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  fire3_squeeze_pkg::bias_bank_t        bias_mem,
  input  logic                                 frame_start,
  input  logic [fire3_squeeze_pkg::ACC_W-1:0]  acc_data,
  input  logic                                 acc_valid,
  output logic                                 acc_ready,
  output logic [fire3_squeeze_pkg::OUT_W-1:0]  out_data,
  output fire3_squeeze_pkg::ch_idx_t           out_ch,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 frame_done,
  output logic [15:0]                          sat_count
);

  import fire3_squeeze_pkg::*;

  localparam int               PIX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);
  localparam ch_idx_t          LAST_CH  = ch_idx_t'(NUM_CH - 1);

  // Input-side position
  logic             r_rdy_en;
  ch_idx_t          r_ch_cnt;
  logic [PIX_W-1:0] r_pix_cnt;
  ch_idx_t          w_ch_eff;
  logic [PIX_W-1:0] w_pix_eff;
  logic             w_accept;

  // Pipeline
  logic                    r_s1_valid;
  logic signed [SUM_W-1:0] r_s1_sum;
  ch_idx_t                 r_s1_ch;
  logic                    r_s2_valid;
  out_t                    r_s2_data;
  ch_idx_t                 r_s2_ch;
  logic                    r_s2_last;
  logic                    w_s1_adv;
  logic                    w_out_hs;
  acc_t                    w_bias;
  logic signed [SUM_W-1:0] w_sum;
  out_t                    w_rq_value;
  logic                    w_rq_sat;

  // Output-side position
  logic [PIX_W-1:0] r_out_pix_cnt;
  logic             r_frame_done;

  // A frame_start in the same cycle as an accept tags that beat as channel 0 / pixel 0.
  assign w_ch_eff  = frame_start ? '0 : r_ch_cnt;
  assign w_pix_eff = frame_start ? '0 : r_pix_cnt;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign acc_ready = r_rdy_en && (!r_s1_valid || w_s1_adv);
  assign w_accept  = acc_valid && acc_ready;
  assign w_out_hs  = r_s2_valid && out_ready;

  assign w_bias = bias_mem[w_ch_eff];
  assign w_sum  = $signed({acc_data[ACC_W-1], acc_data}) + $signed({w_bias[ACC_W-1], w_bias});

  fire_requant_relu #(
    .SUM_W      (SUM_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_requant (
    .i_sum   (r_s1_sum),
    .o_value (w_rq_value),
    .o_sat   (w_rq_sat)
  );

  // Hold off input acceptance until the first cycle after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdy_en <= 1'b0;
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    else     r_rdy_en <= 1'b1;
  end

  // Channel / pixel counters on the input side; wrap at the end of a pixel and of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      if (w_ch_eff == LAST_CH) begin
        r_ch_cnt  <= '0;
        r_pix_cnt <= (w_pix_eff == LAST_PIX) ? '0 : w_pix_eff + 1'b1;
      end else begin
        r_ch_cnt  <= w_ch_eff + 1'b1;
        r_pix_cnt <= w_pix_eff;
      end
    end else begin
      r_ch_cnt  <= w_ch_eff;
      r_pix_cnt <= w_pix_eff;
    end
  end

  // S1: register the biased sum and its channel tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_ch    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_sum   <= w_sum;
      r_s1_ch    <= w_ch_eff;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: register the requantized result; holds while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ch    <= '0;
      r_s2_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_rq_value;
        r_s2_ch   <= r_s1_ch;
        r_s2_last <= (r_s1_ch == LAST_CH);
      end
    end
  end

  // Output-side pixel counter and the end-of-frame pulse after the final beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_pix_cnt <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_out_hs && r_s2_last && (r_out_pix_cnt == LAST_PIX);
      if (frame_start) begin
        r_out_pix_cnt <= '0;
      end else if (w_out_hs && r_s2_last) begin
        r_out_pix_cnt <= (r_out_pix_cnt == LAST_PIX) ? '0 : r_out_pix_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign out_ch     = r_s2_ch;
  assign out_last   = r_s2_last;
  assign frame_done = r_frame_done;

`ifdef FIRE3_SQUEEZE_SAT_STATS_EN
  logic        r_s2_sat;
  logic [15:0] r_sat_count;
  logic        w_unused_pix;

  // Carry the saturation flag alongside the S2 data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_s2_sat <= 1'b0;
    else if (w_s1_adv && r_s1_valid) r_s2_sat <= w_rq_sat;
  end

  // Count saturated beats as they leave; sticks at all-ones, cleared by frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_sat_count <= '0;
    else if (frame_start)                          r_sat_count <= '0;
    else if (w_out_hs && r_s2_sat && (r_sat_count != 16'hFFFF))
                                                   r_sat_count <= r_sat_count + 16'd1;
  end

  assign sat_count    = r_sat_count;
  // The input pixel position is tracked for frame wrap only; it has no output of its own.
  assign w_unused_pix = ^r_pix_cnt;
`else
  logic w_unused_pix;

  assign sat_count    = '0;
  // Without statistics the saturation flag and input pixel position have no consumer.
  assign w_unused_pix = ^{r_pix_cnt, w_rq_sat};
`endif

endmodule
